// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants and types for the multi-channel PWM block.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int ADDR_CTRL       = 0;
    localparam int ADDR_PERIOD     = 1;
    localparam int ADDR_DUTY0      = 2;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CENTER_BIT = 1;
    localparam int CTRL_SWEEP_LSB  = 2;

    typedef enum logic [0:0] {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM lane: active duty register, sweep stepping, comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int CNT_W = 8,
    parameter int STEP  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             running,
    input  logic             boundary,
    input  logic             sweep_en,
    input  logic             duty_wr,
    input  logic [CNT_W-1:0] duty_sh_next,
    input  logic [CNT_W-1:0] period_act,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out
);

    logic [CNT_W-1:0] r_duty_act;
    logic             r_pending;
    logic             r_pwm;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_swept;

    // Sum kept one bit wider so an overshoot past the period is detected, not wrapped.
    assign w_sum   = {1'b0, r_duty_act} + (CNT_W+1)'(STEP);
    assign w_swept = (w_sum > {1'b0, period_act}) ? '0 : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_duty_act <= '0;
            r_pending  <= 1'b0;
            r_pwm      <= 1'b0;
        end else begin
            r_pwm <= running && (cnt < r_duty_act);
            if (!running) begin
                r_duty_act <= duty_sh_next;
                r_pending  <= 1'b0;
            end else if (boundary) begin
                r_pending <= 1'b0;
                if (r_pending || duty_wr || !sweep_en) begin
                    r_duty_act <= duty_sh_next;
                end else begin
                    r_duty_act <= w_swept;
                end
            end else if (duty_wr) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign pwm_out = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel
// Description : Shared-counter PWM with double-buffered duty, edge/center modes.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int STEP     = 5,
    parameter int ADDR_W   = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CNT_W-1:0]    cfg_wdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                cycle_start,
    output logic [CNT_W-1:0]    cnt_dbg
);

    logic                r_en;
    logic                r_center_cfg;
    logic [CHANNELS-1:0] r_sweep_en;
    logic [CNT_W-1:0]    r_period_sh;
    logic [CNT_W-1:0]    r_period_act;
    logic [CNT_W-1:0]    r_duty_sh [CHANNELS];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_down;
    pwm_mode_e           r_mode;
    logic                r_cycle_start;

    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic [CHANNELS-1:0] w_duty_wr;
    logic [CHANNELS-1:0] w_sweep_wdata;
    logic [CNT_W-1:0]    w_duty_sh_next [CHANNELS];
    logic [CNT_W-1:0]    w_period_sh_next;
    logic                w_center_next;
    logic                w_running;
    logic                w_wrap;
    logic                w_boundary;
    logic                w_unused_wdata;

    assign w_wr_ctrl        = cfg_we && (cfg_addr == ADDR_W'(ADDR_CTRL));
    assign w_wr_period      = cfg_we && (cfg_addr == ADDR_W'(ADDR_PERIOD));
    assign w_period_sh_next = w_wr_period ? cfg_wdata : r_period_sh;
    assign w_center_next    = w_wr_ctrl ? cfg_wdata[CTRL_CENTER_BIT] : r_center_cfg;
    assign w_unused_wdata   = ^cfg_wdata;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_decode
            assign w_duty_wr[i]      = cfg_we && (cfg_addr == ADDR_W'(ADDR_DUTY0 + i));
            assign w_duty_sh_next[i] = w_duty_wr[i] ? cfg_wdata : r_duty_sh[i];
            if (CTRL_SWEEP_LSB + i < CNT_W) begin : g_sweep_bit
                assign w_sweep_wdata[i] = cfg_wdata[CTRL_SWEEP_LSB + i];
            end else begin : g_sweep_none
                assign w_sweep_wdata[i] = 1'b0;
            end
        end
    endgenerate

    assign w_running = r_en && (r_period_act != '0);

    // Center mode with P=1 never goes down: 0,1 then straight back to 0.
    always_comb begin
        w_wrap = 1'b0;
        if (r_mode == PWM_EDGE) begin
            w_wrap = (r_cnt >= r_period_act);
        end else if (r_down) begin
            w_wrap = (r_cnt <= CNT_W'(1));
        end else begin
            w_wrap = (r_period_act == CNT_W'(1)) && (r_cnt >= r_period_act);
        end
    end

    assign w_boundary = w_running && w_wrap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en          <= 1'b0;
            r_center_cfg  <= 1'b0;
            r_sweep_en    <= '0;
            r_period_sh   <= '0;
            r_period_act  <= '0;
            r_cnt         <= '0;
            r_down        <= 1'b0;
            r_mode        <= PWM_EDGE;
            r_cycle_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_en         <= cfg_wdata[CTRL_EN_BIT];
                r_center_cfg <= cfg_wdata[CTRL_CENTER_BIT];
                r_sweep_en   <= w_sweep_wdata;
            end
            r_period_sh <= w_period_sh_next;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i] <= w_duty_sh_next[i];
            end

            if (!w_running) begin
                r_cnt         <= '0;
                r_down        <= 1'b0;
                r_period_act  <= w_period_sh_next;
                r_mode        <= w_center_next ? PWM_CENTER : PWM_EDGE;
                r_cycle_start <= 1'b0;
            end else begin
                r_cycle_start <= (r_cnt == '0);
                if (w_wrap) begin
                    r_cnt        <= '0;
                    r_down       <= 1'b0;
                    r_period_act <= w_period_sh_next;
                    r_mode       <= w_center_next ? PWM_CENTER : PWM_EDGE;
                end else if ((r_mode == PWM_EDGE) || (!r_down && (r_cnt < r_period_act))) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt  <= r_cnt - CNT_W'(1);
                    r_down <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            pwm_channel #(
                .CNT_W (CNT_W),
                .STEP  (STEP)
            ) u_channel (
                .clk          (clk),
                .rst          (rst),
                .running      (w_running),
                .boundary     (w_boundary),
                .sweep_en     (r_sweep_en[i]),
                .duty_wr      (w_duty_wr[i]),
                .duty_sh_next (w_duty_sh_next[i]),
                .period_act   (r_period_act),
                .cnt          (r_cnt),
                .pwm_out      (pwm_out[i])
            );
        end
    endgenerate

    assign cycle_start = r_cycle_start;
    assign cnt_dbg     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_channel
// Description : Directed self-checking bench for pwm_multi_channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_channel;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam int STEP     = 5;
    localparam int ADDR_W   = $clog2(CHANNELS + 2);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_we = 1'b0;
    logic [ADDR_W-1:0]   cfg_addr = '0;
    logic [CNT_W-1:0]    cfg_wdata = '0;
    logic [CHANNELS-1:0] pwm_out;
    logic                cycle_start;
    logic [CNT_W-1:0]    cnt_dbg;

    int errors = 0;
    int checks = 0;

    pwm_multi_channel #(
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .STEP     (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start),
        .cnt_dbg     (cnt_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = ADDR_W'(addr);
        cfg_wdata = CNT_W'(data);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic do_reset();
        cfg_we = 1'b0;
        rst    = 1'b0;
        tick();
        tick();
        rst    = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pwm_out !== 4'b0000 || cycle_start !== 1'b0 || cnt_dbg !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: pwm=%b cs=%b cnt=%0d, need pwm=0000 cs=0 cnt=0",
                     pwm_out, cycle_start, cnt_dbg);
        end
    endtask

    // Edge P=4, duty 2: pwm 1,1,0,0,0 and cycle_start every 5th clock.
    task automatic test_edge();
        do_reset();
        cfg_write(1, 4);
        cfg_write(2, 2);
        cfg_write(0, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (pwm_out[0] !== (((k - 1) % 5) < 2) || cycle_start !== (((k - 1) % 5) == 0)
                || cnt_dbg !== CNT_W'(k % 5)) begin
                errors++;
                $display("FAIL edge k=%0d: pwm0=%b cs=%b cnt=%0d, need pwm0=%b cs=%b cnt=%0d",
                         k, pwm_out[0], cycle_start, cnt_dbg,
                         (((k - 1) % 5) < 2), (((k - 1) % 5) == 0), k % 5);
            end
        end
    endtask

    // Center P=4, duty 2: cnt 0,1,2,3,4,3,2,1; 3 of 8 high.
    task automatic test_center();
        int seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int highs = 0;
        do_reset();
        cfg_write(1, 4);
        cfg_write(2, 2);
        cfg_write(0, 3);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k <= 8 && pwm_out[0] === 1'b1) highs++;
            checks++;
            if (cnt_dbg !== CNT_W'(seq[k % 8]) || pwm_out[0] !== (seq[(k - 1) % 8] < 2)
                || cycle_start !== (((k - 1) % 8) == 0)) begin
                errors++;
                $display("FAIL center k=%0d: cnt=%0d pwm0=%b cs=%b, need cnt=%0d pwm0=%b cs=%b",
                         k, cnt_dbg, pwm_out[0], cycle_start, seq[k % 8],
                         (seq[(k - 1) % 8] < 2), (((k - 1) % 8) == 0));
            end
        end
        checks++;
        if (highs != 3) begin
            errors++;
            $display("FAIL center_high_count: got %0d, need 3", highs);
        end
    endtask

    // Duty 2->4 written mid-period: this period 2 high, next period 4 high.
    task automatic test_shadow();
        do_reset();
        cfg_write(1, 4);
        cfg_write(2, 2);
        cfg_write(0, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            cfg_we = 1'b0;
            if (k == 2) begin
                cfg_we    = 1'b1;
                cfg_addr  = ADDR_W'(2);
                cfg_wdata = CNT_W'(4);
            end
            checks++;
            if (pwm_out[0] !== (((k - 1) % 5) < ((k <= 5) ? 2 : 4))) begin
                errors++;
                $display("FAIL shadow k=%0d: pwm0=%b, need %b", k, pwm_out[0],
                         (((k - 1) % 5) < ((k <= 5) ? 2 : 4)));
            end
        end
        cfg_we = 1'b0;
    endtask

    // Sweep on ch1, P=20: high clocks per period 0,5,10,15,20,0.
    task automatic test_sweep();
        int exp_hi [6] = '{0, 5, 10, 15, 20, 0};
        int hi1;
        int hi0;
        do_reset();
        cfg_write(1, 20);
        cfg_write(3, 0);
        cfg_write(0, 9);
        for (int p = 0; p < 6; p++) begin
            hi1 = 0;
            hi0 = 0;
            for (int k = 0; k < 21; k++) begin
                tick();
                if (pwm_out[1] === 1'b1) hi1++;
                if (pwm_out[0] === 1'b1) hi0++;
            end
            checks++;
            if (hi1 != exp_hi[p] || hi0 != 0) begin
                errors++;
                $display("FAIL sweep period=%0d: ch1 high=%0d ch0 high=%0d, need ch1=%0d ch0=0",
                         p, hi1, hi0, exp_hi[p]);
            end
        end
    endtask

    // Duty 0 constant low, duty P+1 constant high, P=0 idle.
    task automatic test_limits();
        do_reset();
        cfg_write(1, 4);
        cfg_write(2, 0);
        cfg_write(3, 5);
        cfg_write(0, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (pwm_out[1:0] !== 2'b10) begin
                errors++;
                $display("FAIL limits_duty k=%0d: pwm[1:0]=%b, need 10", k, pwm_out[1:0]);
            end
        end
        do_reset();
        cfg_write(2, 2);
        cfg_write(0, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (pwm_out !== 4'b0000 || cycle_start !== 1'b0 || cnt_dbg !== 8'd0) begin
                errors++;
                $display("FAIL limits_p0 k=%0d: pwm=%b cs=%b cnt=%0d, need 0000 0 0",
                         k, pwm_out, cycle_start, cnt_dbg);
            end
        end
    endtask

    // One-clock reset pulse mid-period clears everything, including config.
    task automatic test_mid_reset();
        do_reset();
        cfg_write(1, 4);
        cfg_write(2, 2);
        cfg_write(0, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (pwm_out !== 4'b0000 || cycle_start !== 1'b0 || cnt_dbg !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: pwm=%b cs=%b cnt=%0d, need 0000 0 0",
                     pwm_out, cycle_start, cnt_dbg);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (pwm_out !== 4'b0000 || cnt_dbg !== 8'd0) begin
                errors++;
                $display("FAIL mid_reset_idle k=%0d: pwm=%b cnt=%0d, need 0000 0",
                         k, pwm_out, cnt_dbg);
            end
        end
        // Period shadow was cleared, so enabling alone must not start counting.
        cfg_write(0, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (cnt_dbg !== 8'd0 || cycle_start !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_cleared k=%0d: cnt=%0d cs=%b, need 0 0",
                         k, cnt_dbg, cycle_start);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_sweep();
        test_limits();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
